// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit driving the register-file writeback port.
// Optional macro FAST_MUL_EN: single-cycle multiply in the MUL state (default: 32-step shift-add).
module muldiv_unit #(
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          funct3,
    input  logic [WORDSIZE-1:0] rs1Data,
    input  logic [WORDSIZE-1:0] rs2Data,
    input  logic [4:0]          rdAddr,
    output logic                busy,
    output logic                done,
    output logic                regWrite,
    output logic [4:0]          writeReg,
    output logic [WORDSIZE-1:0] writeData
);
    localparam int unsigned W    = WORDSIZE;
    localparam int unsigned CNTW = $clog2(WORDSIZE);
    localparam logic [CNTW-1:0] LASTSTEP = CNTW'(WORDSIZE - 1);
    localparam logic [W-1:0]    MINNEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateType;

    stateType        state;
    logic [2:0]      op;
    logic [4:0]      rdLatched;
    logic [CNTW-1:0] cnt;
    logic            negFlag;
    logic            remNeg;
    logic [W-1:0]    operand;
    logic [2*W-1:0]  acc;

    logic           aSigned, bSigned, signA, signB, divZero, divOvf, divGe;
    logic [W-1:0]   absA, absB, divRem, quoRes, remRes, result;
    logic [W:0]     remShift;
    logic [2*W-1:0] divNext, mulRes;
`ifdef FAST_MUL_EN
    logic [2*W-1:0] fastProduct;
`else
    logic [W:0]     mulSum;
    logic [2*W-1:0] mulNext;
`endif

    // Operand decode, single datapath steps and final sign fix-up
    always_comb begin
        aSigned  = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        bSigned  = aSigned && (funct3 != 3'b010);
        signA    = aSigned && rs1Data[W-1];
        signB    = bSigned && rs2Data[W-1];
        absA     = signA ? -rs1Data : rs1Data;
        absB     = signB ? -rs2Data : rs2Data;
        divZero  = (rs2Data == '0);
        divOvf   = !funct3[0] && (rs1Data == MINNEG) && (rs2Data == '1);

        remShift = {acc[2*W-1:W], acc[W-1]};
        divGe    = (remShift >= {1'b0, operand});
        divRem   = remShift[W-1:0] - operand;
        divNext  = {divGe ? divRem : remShift[W-1:0], acc[W-2:0], divGe};
`ifdef FAST_MUL_EN
        fastProduct = (2*W)'(operand) * (2*W)'(acc[W-1:0]);
`else
        mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        mulNext  = {mulSum, acc[W-1:1]};
`endif

        mulRes   = negFlag ? -acc : acc;
        quoRes   = negFlag ? -acc[W-1:0] : acc[W-1:0];
        remRes   = remNeg ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (op[2])
            result = op[1] ? remRes : quoRes;
        else if (op[1:0] == 2'b00)
            result = mulRes[W-1:0];
        else
            result = mulRes[2*W-1:W];
    end

    // Control FSM; acc holds {hi, lo} of the product, or {remainder, quotient} when dividing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            rdLatched <= '0;
            cnt       <= '0;
            negFlag   <= 1'b0;
            remNeg    <= 1'b0;
            operand   <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            done     <= 1'b0;
            regWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op        <= funct3;
                        rdLatched <= rdAddr;
                        cnt       <= '0;
                        negFlag   <= signA ^ signB;
                        remNeg    <= signA;
                        busy      <= 1'b1;
                        if (!funct3[2]) begin
                            state   <= MUL;
                            operand <= absA;
                            acc     <= {{W{1'b0}}, absB};
                        end else if (divZero) begin
                            state   <= DONE;
                            negFlag <= 1'b0;
                            remNeg  <= 1'b0;
                            acc     <= {rs1Data, {W{1'b1}}};
                        end else if (divOvf) begin
                            state   <= DONE;
                            negFlag <= 1'b0;
                            remNeg  <= 1'b0;
                            acc     <= {{W{1'b0}}, MINNEG};
                        end else begin
                            state   <= DIV;
                            operand <= absB;
                            acc     <= {{W{1'b0}}, absA};
                        end
                    end
                end
                MUL: begin
`ifdef FAST_MUL_EN
                    acc   <= fastProduct;
                    state <= DONE;
`else
                    acc <= mulNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LASTSTEP)
                        state <= DONE;
`endif
                end
                DIV: begin
                    acc <= divNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LASTSTEP)
                        state <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    regWrite  <= (rdLatched != 5'd0);
                    writeReg  <= rdLatched;
                    writeData <= result;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file read ports: it consumes readData1/readData2 for an M-extension instruction. It drives a writeback request (regWrite, writeReg, writeData) that feeds the register file write port. Multi-cycle; the pipeline control holds the core while busy is high.

Parameters:
WORDSIZE, 32, operand/result width; only 32 is supported (RV32M).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; accepted only in IDLE
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1Data  input  32  operand A (from readData1)
rs2Data  input  32  operand B (from readData2)
rdAddr  input  5  destination register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
regWrite  output  1  writeback enable = done & (rdAddr_latched != 0)
writeReg  output  5  latched rdAddr
writeData  output  32  result

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; all outputs 0; internal accumulators/counter 0; operation in flight is discarded, no writeback.
- States: IDLE, MUL, DIV, DONE.
- IDLE: on an edge with start=1, latch funct3, rdAddr, rs1Data, rs2Data, and compute sign flags/absolute values. Go to MUL if funct3[2]=0, else to DIV. Counter=0.
- Signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed.
- MUL: one shift-add step per cycle on |A|,|B| into a 64-bit product. After 32 steps go to DONE. Negate the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]; the others return product[63:32].
- DIV: one restoring step per cycle on |A|/|B|; after 32 steps go to DONE.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the dividend sign.
- Special cases, decided at acceptance with no iteration (IDLE -> DONE next edge):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1Data, for both signed and unsigned.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- DONE: done=1, writeData valid, regWrite per rule above, for exactly one cycle; then IDLE.
- Latency: done asserts 33 cycles after the accepting edge for iterative ops, 1 cycle for special cases.
- busy is high in MUL, DIV and DONE, and low in IDLE.
  - start with busy=1 is ignored. No queuing. The latched operands are unaffected by input changes.
  - start may be issued in the cycle after done (back-to-back).
- writeData/writeReg hold their last value after done; regWrite/done are low outside DONE.
- rdAddr=0: the operation runs normally, done pulses, regWrite stays 0.

Optional Feature:
FAST_MUL_EN: when defined, the MUL state performs a single-cycle combinational 33x33 signed multiply. IDLE->MUL->DONE gives done 2 cycles after acceptance; DIV is unchanged. When undefined, multiply is iterative with 33-cycle latency as above. Results must be bit-identical in both builds.

Test Plan:
- MUL 7 x -3 (rs1=0x7, rs2=0xFFFFFFFD, rd=5) -> done at cycle 33, writeData=0xFFFFFFEB, regWrite=1, writeReg=5.
- MULH/MULHSU/MULHU with rs1=rs2=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by zero rs1=0x1234 -> quotient 0xFFFFFFFF and REM 0x1234, done one cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
- start re-pulsed while busy, and rdAddr=0 case -> second start ignored, single done; rd=0 gives done=1 and regWrite=0.
- rst asserted asynchronously at iteration 10 of a DIV -> busy/done/regWrite drop immediately to 0. A new start after release completes correctly with no stale writeback.
